// File: rtl/match_ctrl.sv
// Match sequencer: frame divider, serve/play/point/match-end flow, scoring and physics gating.
// Optional pause support is compiled in with MATCH_CTRL_PAUSE_EN.
module match_ctrl #(
  parameter int CLK_DIV      = 1666667,
  parameter int SERVE_FRAMES = 90,
  parameter int POINT_FRAMES = 60,
  parameter int WIN_SCORE    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       phys_game_over,
  input  logic [1:0] phys_winner,
  input  logic       phys_valid,
  output logic       phys_en,
  output logic       phys_rst,
  output logic       frame_tick,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] match_winner,
  output logic [2:0] state,
  output logic [6:0] frames_left
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SERVE     = 3'd1,
    S_PLAY      = 3'd2,
    S_POINT     = 3'd3,
    S_MATCH_END = 3'd4,
    S_PAUSED    = 3'd5
  } st_e;

  st_e           state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [6:0]    fl_q, fl_d;
  logic [3:0]    p1_q, p1_d, p2_q, p2_d;
  logic [1:0]    mw_q, mw_d;
  logic          en_q, en_d, prst_q, prst_d;
  logic          start_q, go_q;
  logic          start_edge, point_edge, point_ok;

  assign frame_tick = (div_q == DW'(CLK_DIV - 1));
  assign div_d      = frame_tick ? '0 : div_q + 1'b1;
  assign start_edge = start_btn & ~start_q;
  // game_over history only advances on valid strobes, so a held flag scores once
  assign point_edge = phys_valid & phys_game_over & ~go_q;
  assign point_ok   = point_edge & ((phys_winner == 2'd1) | (phys_winner == 2'd2));

`ifdef MATCH_CTRL_PAUSE_EN
  logic pause_q, pause_edge;
  assign pause_edge = pause_btn & ~pause_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) pause_q <= 1'b0;
    else     pause_q <= pause_btn;
`else
  logic unused_pause;
  assign unused_pause = pause_btn;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      fl_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      mw_q    <= '0;
      en_q    <= 1'b0;
      prst_q  <= 1'b1;
      start_q <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      fl_q    <= fl_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      mw_q    <= mw_d;
      en_q    <= en_d;
      prst_q  <= prst_d;
      start_q <= start_btn;
      if (phys_valid) go_q <= phys_game_over;
    end
  end

  always_comb begin
    state_d = state_q;
    fl_d    = fl_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    mw_d    = mw_q;
    case (state_q)
      S_IDLE: if (start_edge) begin
        p1_d    = '0;
        p2_d    = '0;
        mw_d    = '0;
        fl_d    = 7'(SERVE_FRAMES);
        state_d = S_SERVE;
      end
      S_SERVE: if (frame_tick) begin
        if (fl_q <= 7'd1) begin
          fl_d    = '0;
          state_d = S_PLAY;
        end else fl_d = fl_q - 7'd1;
      end
      S_PLAY: begin
        if (point_ok) begin
          if (phys_winner == 2'd1) p1_d = p1_q + 4'd1;
          else                     p2_d = p2_q + 4'd1;
          fl_d    = 7'(POINT_FRAMES);
          state_d = S_POINT;
        end
`ifdef MATCH_CTRL_PAUSE_EN
        else if (pause_edge) state_d = S_PAUSED;
`endif
      end
      S_POINT: if (frame_tick) begin
        if (fl_q <= 7'd1) begin
          fl_d = '0;
          if (p1_q == 4'(WIN_SCORE)) begin
            mw_d    = 2'd1;
            state_d = S_MATCH_END;
          end else if (p2_q == 4'(WIN_SCORE)) begin
            mw_d    = 2'd2;
            state_d = S_MATCH_END;
          end else begin
            fl_d    = 7'(SERVE_FRAMES);
            state_d = S_SERVE;
          end
        end else fl_d = fl_q - 7'd1;
      end
      S_MATCH_END: if (start_edge) state_d = S_IDLE;
`ifdef MATCH_CTRL_PAUSE_EN
      S_PAUSED: if (pause_edge) state_d = S_PLAY;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // phys_rst is registered from the next state so it lines up with the state it belongs to
  always_comb begin
    en_d   = frame_tick & (state_q == S_PLAY);
    prst_d = (state_d == S_IDLE) | (state_d == S_MATCH_END) |
             ((state_d == S_SERVE) & (state_q != S_SERVE));
  end

  assign phys_en      = en_q;
  assign phys_rst     = prst_q;
  assign p1_score     = p1_q;
  assign p2_score     = p2_q;
  assign match_winner = mw_q;
  assign state        = state_q;
  assign frames_left  = fl_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: directed vector table, hand sequences and a random run against a reference model.
module tb_match_ctrl;
  localparam int CLK_DIV = 4, SERVE_F = 3, POINT_F = 2, WIN = 2;
`ifdef MATCH_CTRL_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b0;
  logic start_btn = 1'b0, pause_btn = 1'b0, phys_game_over = 1'b0, phys_valid = 1'b0;
  logic [1:0] phys_winner = 2'd0;
  logic phys_en, phys_rst, frame_tick;
  logic [3:0] p1_score, p2_score;
  logic [1:0] match_winner;
  logic [2:0] state;
  logic [6:0] frames_left;

  int n_chk = 0, n_err = 0;

  match_ctrl #(.CLK_DIV(CLK_DIV), .SERVE_FRAMES(SERVE_F), .POINT_FRAMES(POINT_F), .WIN_SCORE(WIN)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
    .phys_game_over(phys_game_over), .phys_winner(phys_winner), .phys_valid(phys_valid),
    .phys_en(phys_en), .phys_rst(phys_rst), .frame_tick(frame_tick),
    .p1_score(p1_score), .p2_score(p2_score), .match_winner(match_winner),
    .state(state), .frames_left(frames_left));

  always #5 clk = ~clk;

  // Reference model: per-cycle view of the match rules
  int m_div = 0, m_st = 0, m_fl = 0, m_p1 = 0, m_p2 = 0, m_mw = 0, m_en = 0, m_prst = 1;
  int m_sp = 0, m_pp = 0, m_gp = 0, m_prev;
  bit m_tick, m_se, m_pe, m_pt;

  always @(posedge clk) begin
    if (rst) begin
      m_div = 0; m_st = 0; m_fl = 0; m_p1 = 0; m_p2 = 0; m_mw = 0;
      m_en = 0; m_prst = 1; m_sp = 0; m_pp = 0; m_gp = 0;
    end else begin
      m_tick = (m_div == CLK_DIV - 1);
      m_se   = start_btn && (m_sp == 0);
      m_pe   = PAUSE && pause_btn && (m_pp == 0);
      m_pt   = phys_valid && phys_game_over && (m_gp == 0) && (phys_winner == 1 || phys_winner == 2);
      m_en   = (m_tick && m_st == 2) ? 1 : 0;
      m_prev = m_st;
      case (m_st)
        0: if (m_se) begin m_p1 = 0; m_p2 = 0; m_mw = 0; m_fl = SERVE_F; m_st = 1; end
        1: if (m_tick) begin m_fl--; if (m_fl == 0) m_st = 2; end
        2: if (m_pt) begin
             if (phys_winner == 1) m_p1++; else m_p2++;
             m_fl = POINT_F; m_st = 3;
           end else if (m_pe) m_st = 5;
        3: if (m_tick) begin
             m_fl--;
             if (m_fl == 0) begin
               if (m_p1 == WIN)      begin m_mw = 1; m_st = 4; end
               else if (m_p2 == WIN) begin m_mw = 2; m_st = 4; end
               else begin m_fl = SERVE_F; m_st = 1; end
             end
           end
        4: if (m_se) m_st = 0;
        5: if (m_pe) m_st = 2;
        default: m_st = 0;
      endcase
      m_prst = (m_st == 0 || m_st == 4 || (m_st == 1 && m_prev != 1)) ? 1 : 0;
      m_div  = (m_div + 1) % CLK_DIV;
      m_sp   = start_btn;
      m_pp   = pause_btn;
      if (phys_valid) m_gp = phys_game_over;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    logic [22:0] got, exp;
    @(posedge clk); #1;
    got = {frame_tick, phys_en, phys_rst, state, frames_left, p1_score, p2_score, match_winner};
    exp = {m_div == CLK_DIV - 1, 1'(m_en), 1'(m_prst), 3'(m_st), 7'(m_fl), 4'(m_p1), 4'(m_p2), 2'(m_mw)};
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL model @%0t: got %h expected %h", $time, got, exp);
    end
  endtask

  task automatic wait_st(input int st, input int budget, input string nm);
    int i = 0;
    while (int'(state) != st && i < budget) begin step(); i++; end
    check(nm, int'(state), st);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  typedef struct {int st, go, w, v, exp_st, budget, p1, p2, mw, fl, prst;} vec_t;
  vec_t tbl[14];

  int st_l[48], tk_l[48], en_l[48], pr_l[48], fl_l[48];
  int n, idx, kk, fpt, fen, bad;

  initial begin : main
    // Reset values and free-running divider
    #2 rst = 1'b1; #1;
    check("rst.state", int'(state), 0);
    check("rst.phys_rst", int'(phys_rst), 1);
    check("rst.phys_en", int'(phys_en), 0);
    check("rst.tick", int'(frame_tick), 0);
    check("rst.scores", int'({p1_score, p2_score, match_winner}), 0);
    check("rst.frames_left", int'(frames_left), 0);
    step(); step(); rst = 1'b0;
    n = 0; bad = 0; fpt = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (frame_tick) begin n++; if (fpt < 0) fpt = k; end
      if (phys_en || !phys_rst || state != 3'd0) bad++;
    end
    check("idle.tick_count", n, 5);
    check("idle.first_tick", fpt, 3);
    check("idle.outputs", bad, 0);

    // Serve countdown and phys_en timing
    start_btn = 1'b1;
    for (int k = 0; k < 48; k++) begin
      step();
      if (k == 0) start_btn = 1'b0;
      st_l[k] = int'(state); tk_l[k] = int'(frame_tick); en_l[k] = int'(phys_en);
      pr_l[k] = int'(phys_rst); fl_l[k] = int'(frames_left);
    end
    check("serve.entry_state", st_l[0], 1);
    check("serve.entry_rst", pr_l[0], 1);
    n = 0; idx = 0; kk = 0; fpt = -1; fen = -1; bad = 0;
    for (int k = 0; k < 48; k++) begin
      if (st_l[k] == 1 && pr_l[k] == 1) n++;
      if (st_l[k] == 1 && tk_l[k] == 1) begin
        check($sformatf("serve.fl_tick%0d", idx), fl_l[k], 3 - idx);
        idx++; kk = k;
      end
      if (st_l[k] == 2 && tk_l[k] == 1 && fpt < 0) fpt = k;
      if (en_l[k] == 1 && fen < 0) fen = k;
      if (k < 47 && en_l[k+1] != ((tk_l[k] == 1 && st_l[k] == 2) ? 1 : 0)) bad++;
    end
    check("serve.rst_cycles", n, 1);
    check("serve.tick_count", idx, 3);
    check("serve.to_play", st_l[kk+1], 2);
    check("serve.no_en_on_transition", en_l[kk+1], 0);
    check("play.first_en", fen, fpt + 1);
    check("play.en_period", en_l[fen+4], 1);
    check("play.en_pattern", bad, 0);

    // Directed match flow
    do_reset();
    tbl[0]  = '{0,0,0,0, 0, 2, 0,0,0,0,1};
    tbl[1]  = '{1,0,0,0, 1, 2, 0,0,0,3,1};
    tbl[2]  = '{0,0,0,0, 2,20, 0,0,0,0,0};
    tbl[3]  = '{0,1,2,1, 3, 2, 0,1,0,2,0};
    tbl[4]  = '{0,0,0,1, 1,12, 0,1,0,3,1};
    tbl[5]  = '{0,0,0,1, 2,20, 0,1,0,0,0};
    tbl[6]  = '{0,1,2,1, 3, 2, 0,2,0,2,0};
    tbl[7]  = '{0,0,0,1, 4,12, 0,2,2,0,1};
    tbl[8]  = '{1,0,0,1, 0, 2, 0,2,2,0,1};
    tbl[9]  = '{0,0,0,1, 0, 2, 0,2,2,0,1};
    tbl[10] = '{1,0,0,1, 1, 2, 0,0,0,3,1};
    tbl[11] = '{0,0,0,1, 2,20, 0,0,0,0,0};
    tbl[12] = '{0,1,1,1, 3, 2, 1,0,0,2,0};
    tbl[13] = '{0,0,0,1, 1,12, 1,0,0,3,1};
    for (int i = 0; i < 14; i++) begin
      start_btn = 1'(tbl[i].st); phys_game_over = 1'(tbl[i].go);
      phys_winner = 2'(tbl[i].w); phys_valid = 1'(tbl[i].v);
      step();
      wait_st(tbl[i].exp_st, tbl[i].budget, $sformatf("vec%0d.state", i));
      check($sformatf("vec%0d.p1", i), int'(p1_score), tbl[i].p1);
      check($sformatf("vec%0d.p2", i), int'(p2_score), tbl[i].p2);
      check($sformatf("vec%0d.winner", i), int'(match_winner), tbl[i].mw);
      check($sformatf("vec%0d.frames_left", i), int'(frames_left), tbl[i].fl);
      check($sformatf("vec%0d.phys_rst", i), int'(phys_rst), tbl[i].prst);
    end

    // Asynchronous reset mid-match
    #2 rst = 1'b1; #1;
    check("midrst.state", int'(state), 0);
    check("midrst.p1", int'(p1_score), 0);
    check("midrst.phys_rst", int'(phys_rst), 1);
    check("midrst.frames_left", int'(frames_left), 0);
    step(); step(); rst = 1'b0;

    // Held game_over scores once; invalid winner ignored
    phys_game_over = 1'b0; phys_valid = 1'b1;
    start_btn = 1'b1; step(); start_btn = 1'b0;
    wait_st(2, 20, "held.play");
    phys_game_over = 1'b1; phys_winner = 2'd1; step();
    check("held.point_state", int'(state), 3);
    check("held.p1", int'(p1_score), 1);
    n = 0;
    while (state != 3'd2 && n < 40) begin phys_valid = ~phys_valid; step(); n++; end
    check("held.back_to_play", int'(state), 2);
    for (int k = 0; k < 12; k++) begin phys_valid = ~phys_valid; step(); end
    check("held.still_play", int'(state), 2);
    check("held.p1_once", int'(p1_score), 1);
    phys_game_over = 1'b0; phys_valid = 1'b1; step();
    phys_game_over = 1'b1; phys_winner = 2'd3; step();
    check("w3.state", int'(state), 2);
    check("w3.scores", int'({p1_score, p2_score}), 8'h10);

    // Pause
    pause_btn = 1'b1; step();
    check("pause.enter", int'(state), PAUSE ? 5 : 2);
`ifdef MATCH_CTRL_PAUSE_EN
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) begin phys_game_over = 1'b0; phys_valid = 1'b1; end
      if (k == 11) begin phys_game_over = 1'b1; phys_winner = 2'd2; end
      step();
      if (phys_en) n++;
    end
    check("pause.no_en", n, 0);
    check("pause.held", int'(state), 5);
    check("pause.no_point", int'(p2_score), 0);
    pause_btn = 1'b0; step(); pause_btn = 1'b1; step();
    check("pause.resume", int'(state), 2);
    n = 0;
    while (!phys_en && n < 8) begin step(); n++; end
    check("pause.en_resumes", int'(phys_en), 1);
`else
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) pause_btn = ~pause_btn;
      step();
      if (state == 3'd5) n++;
    end
    check("nopause.never5", n, 0);
    check("nopause.play", int'(state), 2);
`endif
    pause_btn = 1'b0;

    // Randomized run against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0)  start_btn = ~start_btn;
      if ($urandom_range(5) == 0)  phys_game_over = ~phys_game_over;
      if ($urandom_range(19) == 0) pause_btn = ~pause_btn;
      phys_valid  = 1'($urandom_range(1));
      phys_winner = 2'($urandom_range(3));
      rst = ($urandom_range(499) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, errors so far %0d", n_err);
    $fatal(1, "timeout");
  end
endmodule
